// File: rtl/libstf_pkg.sv
// Shared stream helpers: FSM state type, prefix-mask and popcount over a 64-lane maximum.
package libstf_pkg;

    localparam int MASK_W = 64;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } pack_state_e;

    function automatic logic [6:0] popcount(input logic [MASK_W-1:0] v);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < MASK_W; i++) begin
            c = c + {6'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [MASK_W-1:0] prefix_mask(input logic [6:0] n);
        logic [MASK_W-1:0] m;
        for (int i = 0; i < MASK_W; i++) begin
            m[i] = (7'(i) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/ndata_i.sv
// Beat-oriented stream of NUM_ELEMENTS lanes with a prefix keep mask and last marker.
interface ndata_i #(
    parameter type data_t       = logic [7:0],
    parameter int  NUM_ELEMENTS = 4
) ();
    data_t                   data [NUM_ELEMENTS];
    logic [NUM_ELEMENTS-1:0] keep;
    logic                    last;
    logic                    valid;
    logic                    ready;

    modport master (output data, output keep, output last, output valid, input ready);
    modport slave  (input data, input keep, input last, input valid, output ready);
endinterface

// File: rtl/beat_packer_chk.sv
// Simulation-only protocol checker: an accepted input keep must be a prefix mask.
module beat_packer_chk #(
    parameter int NUM_ELEMENTS = 4
) (
    input logic                    clk,
    input logic                    rst,
    input logic                    valid,
    input logic                    ready,
    input logic [NUM_ELEMENTS-1:0] keep
);
    localparam logic [NUM_ELEMENTS-1:0] ONE = {{(NUM_ELEMENTS-1){1'b0}}, 1'b1};

    // A prefix mask plus one has no bits in common with the mask itself.
    always @(posedge clk) begin
        if (!rst && valid && ready) begin
            assert ((keep & (keep + ONE)) == '0);
        end
    end

endmodule

// File: rtl/beat_packer_merge.sv
// Combinational concatenation of the residual elements with the incoming beat's kept lanes.
module beat_packer_merge
    import libstf_pkg::*;
#(
    parameter type data_t       = logic [7:0],
    parameter int  NUM_ELEMENTS = 4,
    localparam int CNT_W        = $clog2(NUM_ELEMENTS + 1)
) (
    input  data_t                   res      [NUM_ELEMENTS-1],
    input  logic [CNT_W-1:0]        res_cnt,
    input  data_t                   in_data  [NUM_ELEMENTS],
    input  logic [NUM_ELEMENTS-1:0] in_keep,
    output data_t                   merged   [2*NUM_ELEMENTS-1],
    output logic [CNT_W:0]          total
);
    logic [MASK_W-1:0] keep_ext;
    logic [6:0]        k_cnt;
    logic              unused_cnt_bits;

    // Count the incoming lanes and splice them directly behind the residual.
    always_comb begin
        keep_ext                   = '0;
        keep_ext[NUM_ELEMENTS-1:0] = in_keep;
        k_cnt                      = popcount(keep_ext);
        total                      = {1'b0, res_cnt} + k_cnt[CNT_W:0];
        for (int i = 0; i < 2*NUM_ELEMENTS-1; i++) begin
            merged[i] = (i < NUM_ELEMENTS-1) ? res[i] : res[0];
            for (int m = 0; m < NUM_ELEMENTS; m++) begin
                if (int'(res_cnt) + m == i) begin
                    merged[i] = in_data[m];
                end else begin
                    merged[i] = merged[i];
                end
            end
        end
    end

    assign unused_cnt_bits = ^k_cnt[6:CNT_W+1];

endmodule

// File: rtl/beat_packer.sv
// Repacks prefix-keep beats into dense NUM_ELEMENTS-wide beats; only the final beat of a stream is partial.
module beat_packer
    import libstf_pkg::*;
#(
    parameter type data_t       = logic [7:0],
    parameter int  NUM_ELEMENTS = 4
) (
    input logic   clk,
    input logic   rst,
    ndata_i.slave  in,
    ndata_i.master out
);
    localparam int              CNT_W = $clog2(NUM_ELEMENTS + 1);
    localparam logic [CNT_W:0]  FULL  = (CNT_W+1)'(NUM_ELEMENTS);

    pack_state_e             state_r;
    data_t                   res_r      [NUM_ELEMENTS-1];
    logic [CNT_W-1:0]        res_cnt_r;
    data_t                   out_data_r [NUM_ELEMENTS];
    logic [NUM_ELEMENTS-1:0] out_keep_r;
    logic                    out_last_r;
    logic                    out_valid_r;

    data_t                   merged_s   [2*NUM_ELEMENTS-1];
    logic [CNT_W:0]          total_s;
    logic [CNT_W:0]          over_s;
    logic [CNT_W:0]          mask_cnt_s;
    logic [MASK_W-1:0]       mask_wide_s;
    logic                    slot_free_s;
    logic                    fire_s;
    logic                    unused_bits;

    beat_packer_merge #(.data_t(data_t), .NUM_ELEMENTS(NUM_ELEMENTS)) u_merge (
        .res     (res_r),
        .res_cnt (res_cnt_r),
        .in_data (in.data),
        .in_keep (in.keep),
        .merged  (merged_s),
        .total   (total_s)
    );

    beat_packer_chk #(.NUM_ELEMENTS(NUM_ELEMENTS)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .valid (in.valid),
        .ready (in.ready),
        .keep  (in.keep)
    );

    assign slot_free_s = !out_valid_r || out.ready;
    assign in.ready    = slot_free_s && (state_r == ACCUM);
    assign fire_s      = in.valid && in.ready;
    assign over_s      = total_s - FULL;
    // A flush emits the residual; an accepted last beat emits the merged total.
    assign mask_cnt_s  = (state_r == FLUSH) ? {1'b0, res_cnt_r} : total_s;
    assign mask_wide_s = prefix_mask(7'(mask_cnt_s));
    assign unused_bits = ^{mask_wide_s[MASK_W-1:NUM_ELEMENTS], over_s[CNT_W]};

    assign out.data  = out_data_r;
    assign out.keep  = out_keep_r;
    assign out.last  = out_last_r;
    assign out.valid = out_valid_r;

    // Packing FSM with residual buffer and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ACCUM;
            res_cnt_r   <= '0;
            out_keep_r  <= '0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
            for (int i = 0; i < NUM_ELEMENTS-1; i++) res_r[i] <= '0;
            for (int i = 0; i < NUM_ELEMENTS; i++) out_data_r[i] <= '0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (fire_s) begin
                        if (!in.last && total_s < FULL) begin
                            for (int i = 0; i < NUM_ELEMENTS-1; i++) res_r[i] <= merged_s[i];
                            res_cnt_r   <= total_s[CNT_W-1:0];
                            out_valid_r <= 1'b0;
                        end else if (!in.last || total_s > FULL) begin
                            for (int i = 0; i < NUM_ELEMENTS; i++) out_data_r[i] <= merged_s[i];
                            for (int i = 0; i < NUM_ELEMENTS-1; i++) res_r[i] <= merged_s[NUM_ELEMENTS+i];
                            out_keep_r  <= '1;
                            out_last_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            res_cnt_r   <= over_s[CNT_W-1:0];
                            state_r     <= in.last ? FLUSH : ACCUM;
                        end else begin
                            for (int i = 0; i < NUM_ELEMENTS; i++) out_data_r[i] <= merged_s[i];
                            out_keep_r  <= mask_wide_s[NUM_ELEMENTS-1:0];
                            out_last_r  <= 1'b1;
                            out_valid_r <= 1'b1;
                            res_cnt_r   <= '0;
                        end
                    end else if (slot_free_s) begin
                        out_valid_r <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (slot_free_s) begin
                        for (int i = 0; i < NUM_ELEMENTS; i++) begin
                            out_data_r[i] <= (i < NUM_ELEMENTS-1) ? res_r[i] : res_r[0];
                        end
                        out_keep_r  <= mask_wide_s[NUM_ELEMENTS-1:0];
                        out_last_r  <= 1'b1;
                        out_valid_r <= 1'b1;
                        res_cnt_r   <= '0;
                        state_r     <= ACCUM;
                    end
                end
                default: begin
                    state_r <= ACCUM;
                end
            endcase
        end
    end

endmodule
